color_sensor_scan: RTL and testbench

COLOR_SENSOR_SCAN -- requirements
Module: color_sensor_scan

---
 rtl/color_sensor_pkg.sv | 26 ++
 rtl/freq_edge_counter.sv | 42 ++++
 rtl/color_sensor_scan.sv | 159 +++++++++++++++
 tb/tb_color_sensor_scan.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/color_sensor_pkg.sv
// Shared types and pin codes for the colour-sensor scanner: FSM states,
// sensor filter selections and the colour result encoding.
package color_sensor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    GATE,
    LATCH,
    DECIDE
  } state_t;

  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_BLUE  = 2'b01;
  localparam logic [1:0] FILT_GREEN = 2'b11;
  localparam logic [1:0] FILT_CLEAR = 2'b10;

  localparam logic [1:0] SCALE_IDLE = 2'b11;

  localparam logic [2:0] COL_DARK  = 3'b000;
  localparam logic [2:0] COL_RED   = 3'b001;
  localparam logic [2:0] COL_BLUE  = 3'b010;
  localparam logic [2:0] COL_GREEN = 3'b100;
  localparam logic [2:0] COL_TIE   = 3'b111;

endpackage

// File: rtl/freq_edge_counter.sv
// Two-flop synchroniser for the sensor square wave, rising-edge detector and
// saturating edge counter with synchronous clear and count enable.
module freq_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sig,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_count;
  logic             w_rise;
  logic             w_full;

  assign w_rise  = r_sync2 & ~r_prev;
  assign w_full  = &r_count;
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_count <= '0;
    end else begin
      r_sync1 <= i_sig;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (i_clr)
        r_count <= '0;
      else if (i_en && w_rise && !w_full)
        r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/color_sensor_scan.sv
// Scans red, blue and green through the sensor filter, counts sensor edges in
// a fixed window per channel, removes dark offsets and classifies the colour.
module color_sensor_scan
  import color_sensor_pkg::*;
#(
  parameter int GATE_CYCLES   = 100000,
  parameter int SETTLE_CYCLES = 1000,
  parameter int CNT_W         = 16,
  parameter int OFF_R         = 14,
  parameter int OFF_B         = 11,
  parameter int OFF_G         = 8,
  parameter int MIN_COUNT     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensorFreq,
  input  logic             start,
  input  logic             continuous,
  input  logic [1:0]       scaleSel,
  output logic [1:0]       scale,
  output logic [1:0]       filter,
  output logic [CNT_W-1:0] redFreq,
  output logic [CNT_W-1:0] blueFreq,
  output logic [CNT_W-1:0] greenFreq,
  output logic [2:0]       color,
  output logic             valid,
  output logic             busy
);

  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_t           r_state;
  state_t           w_next;
  logic [TMR_W-1:0] r_timer;
  logic [1:0]       r_filter;
  logic [1:0]       r_scale;
  logic [CNT_W-1:0] r_red;
  logic [CNT_W-1:0] r_blue;
  logic [CNT_W-1:0] r_green;
  logic [2:0]       r_color;
  logic             r_valid;
  logic             w_cntEn;
  logic             w_cntClr;
  logic [CNT_W-1:0] w_raw;
  logic [31:0]      w_off;
  logic [CNT_W-1:0] w_corr;
  logic [2:0]       w_color;

  freq_edge_counter #(.CNT_W(CNT_W)) u_counter (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_sig   (sensorFreq),
    .i_clr   (w_cntClr),
    .i_en    (w_cntEn),
    .o_count (w_raw)
  );

  // The timer restarts on every state change, so it measures time-in-state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_next;
      r_timer <= (w_next != r_state) ? '0 : r_timer + 1'b1;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_cntEn  = 1'b0;
    w_cntClr = 1'b1;
    case (r_state)
      IDLE:   if (start) w_next = SETTLE;
      SETTLE: if (r_timer == TMR_W'(SETTLE_CYCLES - 1)) w_next = GATE;
      GATE: begin
        w_cntEn  = 1'b1;
        w_cntClr = 1'b0;
        if (r_timer == TMR_W'(GATE_CYCLES - 1)) w_next = LATCH;
      end
      LATCH:  w_next = (r_filter == FILT_GREEN) ? DECIDE : SETTLE;
      DECIDE: w_next = continuous ? SETTLE : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_off = 32'd0;
    case (r_filter)
      FILT_RED:   w_off = 32'(OFF_R);
      FILT_BLUE:  w_off = 32'(OFF_B);
      FILT_GREEN: w_off = 32'(OFF_G);
      default:    w_off = 32'd0;
    endcase
  end

  // Offsets may exceed the counter range, so compare in 32 bits.
  assign w_corr = (32'(w_raw) > w_off) ? CNT_W'(32'(w_raw) - w_off) : '0;

  always_comb begin
    w_color = COL_TIE;
    if ((32'(r_red) < 32'(MIN_COUNT)) && (32'(r_blue) < 32'(MIN_COUNT)) &&
        (32'(r_green) < 32'(MIN_COUNT)))
      w_color = COL_DARK;
    else if (r_red > r_blue && r_red > r_green)
      w_color = COL_RED;
    else if (r_blue > r_red && r_blue > r_green)
      w_color = COL_BLUE;
    else if (r_green > r_red && r_green > r_blue)
      w_color = COL_GREEN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_filter <= FILT_CLEAR;
      r_scale  <= SCALE_IDLE;
      r_red    <= '0;
      r_blue   <= '0;
      r_green  <= '0;
      r_color  <= COL_DARK;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= (r_state == DECIDE);
      case (r_state)
        IDLE: if (start) begin
          r_scale  <= scaleSel;
          r_filter <= FILT_RED;
        end
        LATCH: case (r_filter)
          FILT_RED: begin
            r_red    <= w_corr;
            r_filter <= FILT_BLUE;
          end
          FILT_BLUE: begin
            r_blue   <= w_corr;
            r_filter <= FILT_GREEN;
          end
          default: r_green <= w_corr;
        endcase
        DECIDE: begin
          r_color  <= w_color;
          r_filter <= continuous ? FILT_RED : FILT_CLEAR;
        end
        default: ;
      endcase
    end
  end

  assign scale     = r_scale;
  assign filter    = r_filter;
  assign redFreq   = r_red;
  assign blueFreq  = r_blue;
  assign greenFreq = r_green;
  assign color     = r_color;
  assign valid     = r_valid;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_color_sensor_scan.sv
// Directed bench for color_sensor_scan: three instances (reference, red offset
// 14, 2-bit counters) share one sensor wave whose period follows the filter.
module tb_color_sensor_scan;

  logic       clk;
  logic       rst;
  logic       sensor;
  logic       start;
  logic       continuous;
  logic [1:0] scaleSel;

  logic [1:0] scaleA, filterA, scaleB, filterB, scaleC, filterC;
  logic [7:0] redA, blueA, greenA, redB, blueB, greenB;
  logic [1:0] redC, blueC, greenC;
  logic [2:0] colorA, colorB, colorC;
  logic       validA, busyA, validB, busyB, validC, busyC;

  int checks   = 0;
  int failures = 0;
  int perR     = 0;
  int perB     = 0;
  int perG     = 0;
  int cyc;
  int n;
  logic [1:0] f25, f50;

  color_sensor_scan #(.GATE_CYCLES(20), .SETTLE_CYCLES(4), .CNT_W(8), .OFF_R(0),
                      .OFF_B(0), .OFF_G(0), .MIN_COUNT(2)) dutA (
    .clk(clk), .rst(rst), .sensorFreq(sensor), .start(start), .continuous(continuous),
    .scaleSel(scaleSel), .scale(scaleA), .filter(filterA), .redFreq(redA),
    .blueFreq(blueA), .greenFreq(greenA), .color(colorA), .valid(validA), .busy(busyA));

  color_sensor_scan #(.GATE_CYCLES(20), .SETTLE_CYCLES(4), .CNT_W(8), .OFF_R(14),
                      .OFF_B(0), .OFF_G(0), .MIN_COUNT(2)) dutB (
    .clk(clk), .rst(rst), .sensorFreq(sensor), .start(start), .continuous(continuous),
    .scaleSel(scaleSel), .scale(scaleB), .filter(filterB), .redFreq(redB),
    .blueFreq(blueB), .greenFreq(greenB), .color(colorB), .valid(validB), .busy(busyB));

  color_sensor_scan #(.GATE_CYCLES(20), .SETTLE_CYCLES(4), .CNT_W(2), .OFF_R(0),
                      .OFF_B(0), .OFF_G(0), .MIN_COUNT(2)) dutC (
    .clk(clk), .rst(rst), .sensorFreq(sensor), .start(start), .continuous(continuous),
    .scaleSel(scaleSel), .scale(scaleC), .filter(filterC), .redFreq(redC),
    .blueFreq(blueC), .greenFreq(greenC), .color(colorC), .valid(validC), .busy(busyC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Square wave restarts its phase on every filter change; period 0 = held low.
  initial begin
    int phase;
    int per;
    logic [1:0] lastFilt;
    sensor   = 1'b0;
    phase    = 0;
    lastFilt = 2'b10;
    forever begin
      @(negedge clk);
      if (filterA != lastFilt) phase = 0;
      else phase++;
      lastFilt = filterA;
      case (filterA)
        2'b00:   per = perR;
        2'b01:   per = perB;
        2'b11:   per = perG;
        default: per = 0;
      endcase
      sensor = (per == 0) ? 1'b0 : ((phase % per) < (per / 2));
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int r, input int b, input int g);
    perR = r;
    perB = b;
    perG = g;
  endtask

  // Pulses start; cyc=1 is the cycle right after the start-sampling edge.
  task automatic runScan(output int c);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    c = 1;
    check("busy_first", 16'(busyA), 16'd1);
    check("filter_first", 16'(filterA), 16'd0);
    while (!validA && c < 300) begin
      @(posedge clk);
      @(negedge clk);
      c++;
    end
  endtask

  // From a valid cycle, counts cycles to the next valid; pokes start mid-scan.
  task automatic waitNext(output int c, output logic [1:0] s25, output logic [1:0] s50);
    c   = 0;
    s25 = 2'bxx;
    s50 = 2'bxx;
    do begin
      @(posedge clk);
      @(negedge clk);
      c++;
      start = (c == 10);
      if (c == 25) s25 = filterA;
      if (c == 50) s50 = filterA;
    end while (!validA && c < 300);
    start = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    continuous = 1'b0;
    scaleSel   = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_filter", 16'(filterA), 16'h2);
    check("rst_scale", 16'(scaleA), 16'h3);
    check("rst_color", 16'(colorA), 16'h0);
    check("rst_red", 16'(redA), 16'h0);
    check("rst_blue", 16'(blueA), 16'h0);
    check("rst_green", 16'(greenA), 16'h0);
    check("rst_valid", 16'(validA), 16'h0);
    check("rst_busy", 16'(busyA), 16'h0);
    rst = 1'b0;

    applyStimulus(4, 10, 20);
    scaleSel = 2'b01;
    runScan(cyc);
    check("t1_latency", 16'(cyc), 16'd77);
    check("t1_red", 16'(redA), 16'd5);
    check("t1_blue", 16'(blueA), 16'd2);
    check("t1_green", 16'(greenA), 16'd1);
    check("t1_color", 16'(colorA), 16'h1);
    check("t1_scale", 16'(scaleA), 16'h1);
    check("t1_clampB", 16'(redB), 16'd0);
    check("t1_satC", 16'(redC), 16'd3);
    @(posedge clk);
    @(negedge clk);
    check("t1_valid_one", 16'(validA), 16'd0);
    check("t1_idle_busy", 16'(busyA), 16'd0);
    check("t1_idle_filter", 16'(filterA), 16'h2);

    applyStimulus(5, 5, 5);
    runScan(cyc);
    check("t2_red", 16'(redA), 16'd4);
    check("t2_blue", 16'(blueA), 16'd4);
    check("t2_green", 16'(greenA), 16'd4);
    check("t2_color", 16'(colorA), 16'h7);

    applyStimulus(0, 0, 0);
    runScan(cyc);
    check("t3_red", 16'(redA), 16'd0);
    check("t3_green", 16'(greenA), 16'd0);
    check("t3_color", 16'(colorA), 16'h0);

    applyStimulus(0, 10, 0);
    runScan(cyc);
    check("t4_blue", 16'(blueA), 16'd2);
    check("t4_color", 16'(colorA), 16'h2);

    applyStimulus(20, 20, 20);
    runScan(cyc);
    check("t5_red", 16'(redA), 16'd1);
    check("t5_color", 16'(colorA), 16'h0);

    applyStimulus(6, 10, 20);
    runScan(cyc);
    check("t6_redA", 16'(redA), 16'd3);
    check("t6_colorA", 16'(colorA), 16'h1);
    check("t6_redB", 16'(redB), 16'd0);
    check("t6_colorB", 16'(colorB), 16'h2);

    applyStimulus(2, 2, 2);
    runScan(cyc);
    check("t7_redA", 16'(redA), 16'd10);
    check("t7_colorA", 16'(colorA), 16'h7);
    check("t7_redC", 16'(redC), 16'd3);
    check("t7_blueC", 16'(blueC), 16'd3);
    check("t7_greenC", 16'(greenC), 16'd3);
    check("t7_colorC", 16'(colorC), 16'h7);

    applyStimulus(4, 10, 20);
    continuous = 1'b1;
    scaleSel   = 2'b10;
    runScan(cyc);
    check("t8_latency", 16'(cyc), 16'd77);
    check("t8_rescan_filter", 16'(filterA), 16'h0);
    scaleSel = 2'b00;
    waitNext(n, f25, f50);
    check("t8_period", 16'(n), 16'd76);
    check("t8_filter25", 16'(f25), 16'h1);
    check("t8_filter50", 16'(f50), 16'h3);
    check("t8_scale_held", 16'(scaleA), 16'h2);
    check("t8_color", 16'(colorA), 16'h1);
    continuous = 1'b0;
    waitNext(n, f25, f50);
    check("t8_period2", 16'(n), 16'd76);
    @(posedge clk);
    @(negedge clk);
    check("t8_stop_filter", 16'(filterA), 16'h2);
    check("t8_stop_busy", 16'(busyA), 16'd0);

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (34) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("t9_blue_gate", 16'(filterA), 16'h1);
    check("t9_red_latched", 16'(redA), 16'd5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t9_filter", 16'(filterA), 16'h2);
    check("t9_busy", 16'(busyA), 16'd0);
    check("t9_red", 16'(redA), 16'd0);
    check("t9_color", 16'(colorA), 16'h0);
    check("t9_scale", 16'(scaleA), 16'h3);
    check("t9_valid", 16'(validA), 16'd0);
    runScan(cyc);
    check("t9_latency", 16'(cyc), 16'd77);
    check("t9_scan_red", 16'(redA), 16'd5);
    check("t9_scan_blue", 16'(blueA), 16'd2);
    check("t9_scan_green", 16'(greenA), 16'd1);
    check("t9_scan_color", 16'(colorA), 16'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
